// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction at a time over req/gnt/rvalid.
// Zero-wait latency: store 2, load 3, fault 1 cycle; gnt/rvalid stalls add cycles, req_i only taken in IDLE.
module lsu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_done, r_err;
  logic [2:0]  r_f3;
  logic [1:0]  r_a;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;

  logic        w_accept, w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_accept = (r_state == IDLE) && req_i;

  always_comb begin
    w_fault = 1'b0;
    case (funct3_i)
      3'b000:  w_fault = 1'b0;
      3'b001:  w_fault = addr_i[0];
      3'b010:  w_fault = |addr_i[1:0];
      3'b100:  w_fault = we_i;
      3'b101:  w_fault = we_i | addr_i[0];
      default: w_fault = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
      end
    endcase
  end

  // Lane select uses the captured offset, since addr_i may have moved on by rvalid.
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_a)
      2'b00: w_byte = mem_rdata_i[7:0];
      2'b01: w_byte = mem_rdata_i[15:8];
      2'b10: w_byte = mem_rdata_i[23:16];
      2'b11: w_byte = mem_rdata_i[31:24];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half  = r_a[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    w_ldata = mem_rdata_i;
    case (r_f3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ldata = {24'd0, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b101:  w_ldata = {16'd0, w_half};
      default: w_ldata = mem_rdata_i;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_fault) w_next = REQ;
      REQ:     if (mem_gnt_i) w_next = r_we ? IDLE : WAIT;
      WAIT:    if (mem_rvalid_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_a     <= 2'd0;
      r_addr  <= 32'd0;
      r_be    <= 4'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        r_we    <= we_i;
        r_f3    <= funct3_i;
        r_a     <= addr_i[1:0];
        r_addr  <= {addr_i[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
        if (w_fault) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end
      end
      if (r_state == REQ && mem_gnt_i && r_we) r_done <= 1'b1;
      if (r_state == WAIT && mem_rvalid_i) begin
        r_done  <= 1'b1;
        r_rdata <= w_ldata;
      end
    end
  end

  assign ready_o     = (r_state == IDLE);
  assign mem_req_o   = (r_state == REQ);
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;

endmodule
